// File: rtl/vrc7_snd_pkg.sv
// rtl/vrc7_snd_pkg.sv - shared states, widths and saturation helper for the VRC7 sound post stage
package vrc7_snd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HPF,
    LPF,
    MUL,
    OUT
  } state_t;

  localparam int SILENCE_CODE = 1024;
  localparam int X_W          = 12;
  localparam int F_W          = 20;
  localparam int ACC_W        = 21;
  localparam int OUT_W        = 16;

  // Clamp a wide signed value into the range of a w-bit signed number.
  function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi)      sat = hi;
    else if (v < lo) sat = lo;
    else             sat = v;
  endfunction

endpackage

// File: rtl/snd_serial_mul.sv
// rtl/snd_serial_mul.sv - 12x8 signed-by-unsigned shift-add multiplier, one multiplier bit per clock
module snd_serial_mul
  import vrc7_snd_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic signed [X_W-1:0]   i_mcand,
  input  logic [7:0]              i_mplier,
  output logic                    o_done,
  output logic signed [ACC_W-1:0] o_prod
);

  logic signed [ACC_W-1:0] r_mcand;
  logic signed [ACC_W-1:0] r_acc;
  logic [7:0]              r_mplier;
  logic [3:0]              r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_mcand  <= {{(ACC_W - X_W){i_mcand[X_W-1]}}, i_mcand};
      r_acc    <= '0;
      r_mplier <= i_mplier;
      r_cnt    <= 4'd8;
    end else if (r_cnt != 4'd0) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand <<< 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - 4'd1;
    end
  end

  // High during the eighth step; the product is complete after that edge.
  assign o_done = (r_cnt == 4'd1);
  assign o_prod = r_acc;

endmodule

// File: rtl/vrc7_snd_post.sv
// rtl/vrc7_snd_post.sv - DC block, one-pole low-pass and saturating gain for the VRC7 sample stream
module vrc7_snd_post
  import vrc7_snd_pkg::*;
#(
  parameter int HP_SHIFT = 9,
  parameter int LP_SHIFT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_vld,
  input  logic [10:0] i_in_smp,
  input  logic [7:0]  i_gain,
  input  logic        i_mute,
  output logic        o_in_rdy,
  output logic        o_out_vld,
  output logic [15:0] o_out_smp,
  output logic        o_ovf
);

  state_t                  r_state;
  logic signed [X_W-1:0]   r_x;
  logic signed [X_W-1:0]   r_xp;
  logic [7:0]              r_gain;
  logic signed [F_W-1:0]   r_yh;
  logic signed [F_W-1:0]   r_yl;
  logic                    r_in_rdy;
  logic                    r_out_vld;
  logic [OUT_W-1:0]        r_out_smp;
  logic                    r_ovf;

  logic signed [X_W-1:0]   w_x_in;
  logic signed [31:0]      w_x_e;
  logic signed [31:0]      w_xp_e;
  logic signed [31:0]      w_yh_e;
  logic signed [31:0]      w_hp_sum;
  logic signed [F_W-1:0]   w_yh_nxt;
  logic signed [F_W:0]     w_lp_diff;
  logic signed [F_W-1:0]   w_yl_nxt;
  logic signed [X_W-1:0]   w_m;
  logic                    w_mul_start;
  logic                    w_mul_done;
  logic signed [ACC_W-1:0] w_prod;
  logic signed [31:0]      w_prod_e;
  logic signed [31:0]      w_out_sat;

  assign w_x_in = {1'b0, i_in_smp} - X_W'(SILENCE_CODE);

  assign w_x_e    = r_x;
  assign w_xp_e   = r_xp;
  assign w_yh_e   = r_yh;
  assign w_hp_sum = w_yh_e + ((w_x_e - w_xp_e) <<< 8) - (w_yh_e >>> HP_SHIFT);
  assign w_yh_nxt = F_W'(sat(w_hp_sum, F_W));

  // r_yh already holds this sample's high-pass result when LPF runs.
  assign w_lp_diff = {r_yh[F_W-1], r_yh} - {r_yl[F_W-1], r_yl};
  assign w_yl_nxt  = r_yl + F_W'(w_lp_diff >>> LP_SHIFT);
  assign w_m       = w_yl_nxt[F_W-1:8];

  assign w_mul_start = (r_state == LPF);

  snd_serial_mul u_mul (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (w_mul_start),
    .i_mcand  (w_m),
    .i_mplier (r_gain),
    .o_done   (w_mul_done),
    .o_prod   (w_prod)
  );

  assign w_prod_e  = w_prod;
  assign w_out_sat = sat(w_prod_e, OUT_W);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_x       <= '0;
      r_xp      <= '0;
      r_gain    <= '0;
      r_yh      <= '0;
      r_yl      <= '0;
      r_in_rdy  <= 1'b1;
      r_out_vld <= 1'b0;
      r_out_smp <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_out_vld <= 1'b0;
      if (i_in_vld && (r_state != IDLE)) r_ovf <= 1'b1;
      case (r_state)
        IDLE: begin
          if (i_in_vld) begin
            r_x      <= w_x_in;
            r_gain   <= i_gain;
            r_in_rdy <= 1'b0;
            r_state  <= HPF;
          end
        end
        HPF: begin
          r_yh    <= w_yh_nxt;
          r_xp    <= r_x;
          r_state <= LPF;
        end
        LPF: begin
          r_yl    <= w_yl_nxt;
          r_state <= MUL;
        end
        MUL: begin
          if (w_mul_done) r_state <= OUT;
        end
        OUT: begin
          r_out_smp <= i_mute ? '0 : OUT_W'(w_out_sat);
          r_out_vld <= 1'b1;
          r_in_rdy  <= 1'b1;
          r_state   <= IDLE;
        end
        default: begin
          r_in_rdy <= 1'b1;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign o_in_rdy  = r_in_rdy;
  assign o_out_vld = r_out_vld;
  assign o_out_smp = r_out_smp;
  assign o_ovf     = r_ovf;

endmodule

// File: doc/vrc7_snd_post.md
# vrc7_snd_post

Post-processing stage downstream of the VRC7 FM synthesizer, between the synthesizer's 11-bit unsigned sample output and the mapper's 16-bit signed sound bus. Per accepted sample it removes DC, applies a one-pole low-pass to tame aliasing, then scales by a runtime gain with saturation. Arithmetic is time-multiplexed: filter steps plus a serial shift-add multiply, so the block is busy for several clocks per sample.

## Interface
Parameters:
- HP_SHIFT, 9, DC-block pole: y_h loses y_h>>>HP_SHIFT per sample
- LP_SHIFT, 2, low-pass coefficient 2^-LP_SHIFT

Ports:
- clk  in  1  system clock; one clock for the whole block
- rst  in  1  reset; synchronous, active-high
- in_vld  in  1  sample strobe, one-cycle pulse
- in_smp  in  11  unsigned synth sample, 1024 = silence
- gain  in  8  unsigned Q4.4 gain, 16 = unity
- mute  in  1  force output to zero; filters keep running
- in_rdy  out  1  high in IDLE
- out_vld  out  1  one-cycle pulse, new out_smp
- out_smp  out  16  signed output sample, held between pulses
- ovf  out  1  sticky: a sample arrived while busy

## Operation
- States: IDLE -> HPF -> LPF -> MUL (8 cycles) -> OUT -> IDLE.
- IDLE: when in_vld=1 and not rst, capture x = in_smp - 1024 (12-bit signed) and gain; go HPF.
- HPF: y_h = sat20(y_h + ((x - x_prev) << 8) - (y_h >>> HP_SHIFT)); x_prev = x. y_h is 20-bit signed Q12.8.
- LPF: y_l = y_l + ((y_h_new - y_l) >>> LP_SHIFT); y_l 20-bit signed Q12.8, difference computed in 21 bits, no saturation needed.
- MUL: operand m = y_l >>> 8 (12-bit signed, floor). Serial shift-add over the 8 gain bits, LSB first, one bit per cycle, into a 21-bit signed accumulator; product = m * gain.
- OUT: out_smp = mute ? 0 : sat16(product) (clamp to 32767 / -32768); out_vld=1 for this cycle; mute sampled here.
- in_vld outside IDLE: sample dropped, ovf set to 1, state unaffected; ovf cleared only by rst.
- gain changes after capture have no effect on the sample in flight.
- Reset values: state IDLE, in_rdy=1, out_vld=0, out_smp=0, ovf=0, x_prev=y_h=y_l=0, accumulator 0.
- rst mid-operation: aborts; no out_vld for the aborted sample; all filter state returns to zero.

## Timing
- in_vld sampled at edge T0 in IDLE: HPF at T1, LPF at T2, MUL at T3..T10, OUT at T11; out_vld high during cycle after edge T11, i.e. latency 11 clocks.
- in_rdy low from T1 through T11; next sample accepted no earlier than T12. Max throughput one sample per 12 clocks.
- out_vld and in_rdy both registered; no combinational path from inputs to outputs.
- in_vld coincident with rst: ignored, ovf not set.

## Structure
- Shared package vrc7_snd_pkg: state enum (IDLE, HPF, LPF, MUL, OUT), SILENCE_CODE = 1024, widths (X_W=12, F_W=20, ACC_W=21, OUT_W=16), sat helper function.
- One sub-module: snd_serial_mul (start, 12-bit signed multiplicand, 8-bit unsigned multiplier, done after 8 clocks, 21-bit product; synchronous reset).

## Test plan
- Reset: hold rst 3 cycles -> out_smp=0, out_vld=0, in_rdy=1, ovf=0.
- Silence: 50 samples of in_smp=1024, gain=16 -> every out_smp=0, each out_vld exactly 11 clocks after its in_vld.
- First sample after reset, in_smp=2047, gain=16 -> y_h=261888, y_l=65472, m=255, out_smp=4080.
- Saturation: after reset, in_smp=2047, gain=255 -> out_smp=32767; after reset, in_smp=0, gain=255 -> m=-256, out_smp=-32768.
- Overrun: second in_vld 5 clocks after first -> only one out_vld, ovf=1 and stays 1 until rst; mute=1 at OUT -> out_smp=0.
- Reset mid-MUL: rst at T6 -> no out_vld; next sample in_smp=2047, gain=16 -> out_smp=4080.
